serial_byte_deser: RTL
======================

// Module: serial_byte_deser
// PURPOSE
//  Receive end of the byte serial link: collects a bit-serial stream into WIDTH-bit words.
//  Performs the bit-order undo that pairs with the byte bit-reversal stage, so the
//    transmitter may send LSB-first and the consumer still sees a natural byte.
//  Sits between the serial pin/pipeline stage and the byte-wide sequential pipe.
//  Decouples the two sides with a 2-entry output buffer and a valid/ready handshake.
// PARAMETERS
//  WIDTH      8   word width in bits (>=2)
//  MSB_FIRST  1   1: first received bit -> out_byte[WIDTH-1]; 0: first bit -> out_byte[0]
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  sin_valid  in   1      sin_bit is valid this cycle
//  sin_bit    in   1      serial data bit
//  sin_sof    in   1      start-of-word; qualified by sin_valid, marks the first bit of a word
//  out_valid  out  1      out_byte holds a complete word
//  out_ready  in   1      consumer accepts out_byte when out_valid && out_ready
//  out_byte   out  WIDTH  assembled word (head of output buffer)
//  overrun    out  1      one-cycle pulse: completed word dropped, buffer full
//  resync     out  1      one-cycle pulse: sin_sof arrived mid-word, partial word discarded
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_byte=0, overrun=0, resync=0,
//    bit count=0, shift reg=0, buffer empty, FSM=IDLE.
//  FSM states:
//   - IDLE: waits for sin_valid && sin_sof; that bit is captured as bit 0 of the word -> SHIFT.
//     sin_valid without sin_sof in IDLE is ignored.
//   - SHIFT: each sin_valid captures one bit and increments the count.
//     On the WIDTH-th bit the word is complete -> push to buffer, FSM -> IDLE.
//   - The next word always needs sin_sof; no back-to-back words without a marker.
//  Bit placement:
//   - MSB_FIRST=1: shift left, new bit into LSB.
//   - MSB_FIRST=0: shift right, new bit into MSB.
//   - The result for MSB_FIRST=0 equals the bit-reversal of the MSB_FIRST=1 result.
//  Latency: the word is visible on out_byte/out_valid the cycle after its last bit is sampled
//    (buffer empty case).
//  Buffer:
//   - 2 entries, FIFO order.
//   - out_valid = buffer not empty; out_byte = head entry, held stable while out_valid && !out_ready.
//   - Pop when out_valid && out_ready.
//   - Push and pop in the same cycle with 2 entries held: the push succeeds and no overrun is
//     raised (pop frees the slot first).
//   - Push with 2 entries held and no pop: the word is dropped, overrun=1 for one cycle,
//     buffer contents unchanged.
//   - out_byte=0 when the buffer is empty.
//  sin_sof while in SHIFT (count>0):
//   - The partial word is discarded and resync=1 for one cycle.
//   - The current bit starts a new word (count=1).
//  sin_valid=0 cycles: FSM, count and shift reg hold; no timeout.
//  Width rule: the count register is $clog2(WIDTH+1) bits and wraps only via reset to 0
//    on completion.
//  Reset mid-word or with a full buffer: everything is cleared immediately and the partial
//    or buffered data is lost.
// STRUCTURE
//  Shared include (serdes_defs.vh): FSM state encodings S_IDLE=1'b0, S_SHIFT=1'b1;
//    DEFAULT_WIDTH=8.
//  Sub-module byte_buf2 (2-entry FIFO with WIDTH parameter and push/pop/full/empty) holds
//    the output buffer.
//  The top level holds the FSM, bit counter, shift register and the pulse outputs.
// TESTING
//  1 MSB_FIRST=1, send bits 1,0,1,0,0,1,0,1 (sof on first), out_ready=1
//    -> out_byte=8'hA5, out_valid for exactly 1 cycle.
//  2 MSB_FIRST=0, same bit stream -> out_byte=8'hA5 reversed = 8'hA5? no: send 1,0,1,1,0,0,0,0
//    -> out_byte=8'h0D.
//  3 out_ready=0, send 3 words 8'h11,8'h22,8'h33 -> 8'h33 dropped with one overrun pulse;
//    raise out_ready -> reads 8'h11 then 8'h22, then out_valid=0.
//  4 Send 4 bits, then sof with the bits of 8'h3C -> one resync pulse, only 8'h3C delivered.
//  5 Buffer full, pop and complete a word in the same cycle -> no overrun, next reads return
//    the remaining entry then the new word.
//  6 Assert rst mid-word with 1 word buffered -> out_valid=0 and out_byte=0 at once;
//    a fresh word after release is received correctly.

Source files
------------

// File: rtl/serial_byte_deser_pkg.sv
// Shared definitions for the serial byte deserializer: FSM encodings and default width.
package serial_byte_deser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } deser_state_t;

endpackage

// File: rtl/serial_byte_deser_byte_buf2.sv
// byte_buf2: 2-entry FIFO holding completed words for the deserializer output.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   i_push     write i_data (accepted when not full, or when full and popping)
//   i_data     word to write
//   i_pop      remove head entry (ignored when empty)
//   o_head     head entry; zero when empty
//   o_full     both entries occupied
//   o_empty    no entries occupied
module serial_byte_deser_byte_buf2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    // Entry 0 is always the head; vacated entries are zeroed so the head reads 0 when empty.
    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    logic             r_vld0;
    logic             r_vld1;

    logic             w_pop;
    logic             w_push;

    // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
    assign w_pop  = i_pop & r_vld0;
    assign w_push = i_push & (~r_vld1 | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_vld0 <= r_vld1;
                    r_ent1 <= '0;
                    r_vld1 <= 1'b0;
                end
                2'b10: begin
                    if (!r_vld0) begin
                        r_ent0 <= i_data;
                        r_vld0 <= 1'b1;
                    end else begin
                        r_ent1 <= i_data;
                        r_vld1 <= 1'b1;
                    end
                end
                2'b11: begin
                    // Head leaves; new word goes behind whatever remains.
                    if (r_vld1) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_data;
                    end else begin
                        r_ent0 <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_ent0;
    assign o_full  = r_vld1;
    assign o_empty = ~r_vld0;

endmodule

// File: rtl/serial_byte_deser.sv
// serial_byte_deser: collects a bit-serial stream into WIDTH-bit words, undoing the
// transmitter bit order, and hands them out through a 2-entry valid/ready buffer.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   sin_valid   serial bit valid this cycle
//   sin_bit     serial data bit
//   sin_sof     first bit of a word (qualified by sin_valid)
//   out_valid   out_byte holds a complete word
//   out_ready   consumer accepts out_byte when out_valid && out_ready
//   out_byte    head word of the output buffer (0 when empty)
//   overrun     one-cycle pulse: completed word dropped because buffer full
//   resync      one-cycle pulse: sin_sof mid-word, partial word discarded
module serial_byte_deser
    import serial_byte_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_bit,
    input  logic             sin_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_byte,
    output logic             overrun,
    output logic             resync
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    deser_state_t     r_state;
    deser_state_t     w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nx;
    logic             r_overrun;
    logic             r_resync;
    logic             w_overrun_nx;
    logic             w_resync_nx;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_fresh;
    logic             w_push;
    logic [WIDTH-1:0] w_word;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    // MSB-first shifts left (first bit ends at the top); LSB-first shifts right.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST) begin
            shift_in = {cur[WIDTH-2:0], b};
        end else begin
            shift_in = {b, cur[WIDTH-1:1]};
        end
    endfunction

    assign w_shifted = shift_in(r_shift, sin_bit);
    assign w_fresh   = shift_in('0, sin_bit);
    assign w_pop     = out_valid & out_ready;

    // State, counter, shift register and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_overrun <= 1'b0;
            r_resync  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_shift   <= w_shift_nx;
            r_overrun <= w_overrun_nx;
            r_resync  <= w_resync_nx;
        end
    end

    // Next-state and word assembly.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_shift_nx  = r_shift;
        w_push      = 1'b0;
        w_word      = '0;
        w_resync_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sin_valid && sin_sof) begin
                    w_shift_nx = w_fresh;
                    w_cnt_nx   = CNT_W'(1);
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sin_valid) begin
                    if (sin_sof) begin
                        // Restart: this bit becomes bit 0 of a new word.
                        w_resync_nx = 1'b1;
                        w_shift_nx  = w_fresh;
                        w_cnt_nx    = CNT_W'(1);
                    end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_push     = 1'b1;
                        w_word     = w_shifted;
                        w_shift_nx = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_shift_nx = w_shifted;
                        w_cnt_nx   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_overrun_nx = w_push & w_full & ~w_pop;
    end

    serial_byte_deser_byte_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_head  (out_byte),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign overrun   = r_overrun;
    assign resync    = r_resync;

endmodule
